// File: rtl/bsg_link_flit_pkg.sv
// Shared types and constants for the link flit assembler slice.
package bsg_link_flit_pkg;

    typedef enum logic [1:0] {eHeader, eBody, eDiscard, eDone} flit_state_e;

    // Body length lives in the low bits of the header flit.
    localparam int hdr_len_lsb_gp   = 0;
    localparam int hdr_len_width_gp = 8;

    function automatic int slot_idx_width(input int max_body);
        return (max_body < 1) ? 1 : $clog2(max_body + 1);
    endfunction

endpackage

// File: rtl/bsg_link_flit_down_counter.sv
// Loadable down-counter; zero_next_o flags that the next decrement reaches zero.
module bsg_link_flit_down_counter #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_next_o
);

    logic [width_p-1:0] count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            count_r <= '0;
        else if (load_i)
            count_r <= load_val_i;
        else if (dec_i && (count_r != '0))
            count_r <= count_r - width_p'(1);
    end

    assign zero_next_o = (count_r == width_p'(1));

endmodule

// File: rtl/bsg_link_flit_assembler.sv
// Pops link flits and reassembles header+body packets into one wide word;
// oversized packets are drained and flagged so the link never backs up.
module bsg_link_flit_assembler
    import bsg_link_flit_pkg::*;
#(
    parameter int flit_width_p = 64,
    parameter int max_body_p   = 3,
    parameter int len_width_p  = hdr_len_width_gp
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  valid_i,
    input  logic [flit_width_p-1:0]               data_i,
    output logic                                  yumi_o,
    output logic                                  valid_o,
    output logic [(max_body_p+1)*flit_width_p-1:0] data_o,
    output logic [len_width_p-1:0]                len_o,
    input  logic                                  ready_i,
    output logic                                  error_o
);

    localparam int idx_w_lp = slot_idx_width(max_body_p);
    localparam logic [len_width_p-1:0] max_body_len_lp = len_width_p'(max_body_p);

    flit_state_e                             state_r;
    logic [max_body_p:0][flit_width_p-1:0]   slots_r;
    logic [idx_w_lp-1:0]                     idx_r;
    logic [len_width_p-1:0]                  len_r;
    logic [len_width_p-1:0]                  hdr_len;
    logic                                    valid_r;
    logic                                    error_r;
    logic                                    accept;
    logic                                    cnt_load;
    logic                                    cnt_dec;
    logic                                    cnt_last;

    assign hdr_len  = data_i[hdr_len_lsb_gp +: len_width_p];
    // Acceptance is independent of ready_i; eDone is the only stall point.
    assign yumi_o   = valid_i & (state_r != eDone) & ~reset_i;
    assign accept   = yumi_o;
    assign cnt_load = accept & (state_r == eHeader);
    assign cnt_dec  = accept & ((state_r == eBody) | (state_r == eDiscard));

    bsg_link_flit_down_counter #(
        .width_p(len_width_p)
    ) body_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (hdr_len),
        .dec_i      (cnt_dec),
        .zero_next_o(cnt_last)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eHeader;
            slots_r <= '0;
            idx_r   <= '0;
            len_r   <= '0;
            valid_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            error_r <= 1'b0;
            case (state_r)
                eHeader: if (accept) begin
                    slots_r    <= '0;
                    slots_r[0] <= data_i;
                    len_r      <= hdr_len;
                    idx_r      <= idx_w_lp'(1);
                    if (hdr_len == '0) begin
                        state_r <= eDone;
                        valid_r <= 1'b1;
                    end else if (hdr_len <= max_body_len_lp) begin
                        state_r <= eBody;
                    end else begin
                        error_r <= 1'b1;
                        state_r <= eDiscard;
                    end
                end
                eBody: if (accept) begin
                    slots_r[idx_r] <= data_i;
                    idx_r          <= idx_r + idx_w_lp'(1);
                    if (cnt_last) begin
                        state_r <= eDone;
                        valid_r <= 1'b1;
                    end
                end
                eDiscard: if (accept && cnt_last) state_r <= eHeader;
                eDone: if (ready_i) begin
                    valid_r <= 1'b0;
                    state_r <= eHeader;
                end
                default: state_r <= eHeader;
            endcase
        end
    end

    assign valid_o = valid_r;
    assign data_o  = slots_r;
    assign len_o   = len_r;
    assign error_o = error_r;

endmodule

// File: tb/tb_bsg_link_flit_assembler.sv
// Scoreboard bench for the flit assembler: directed packets, monitor-side checking.
module tb_bsg_link_flit_assembler;

    localparam int FW = 64;
    localparam int MB = 3;
    localparam int LW = 8;
    localparam int DW = (MB + 1) * FW;

    typedef struct {
        logic [DW-1:0] data;
        logic [LW-1:0] len;
    } pkt_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          valid_i = 1'b0;
    logic [FW-1:0] data_i = '0;
    logic          yumi_o;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic [LW-1:0] len_o;
    logic          ready_i = 1'b1;
    logic          error_o;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   err_exp = 0;
    pkt_t exp_q[$];
    int   hs_cyc[$];

    bsg_link_flit_assembler #(.flit_width_p(FW), .max_body_p(MB), .len_width_p(LW)) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .valid_i(valid_i),
        .data_i (data_i),
        .yumi_o (yumi_o),
        .valid_o(valid_o),
        .data_o (data_o),
        .len_o  (len_o),
        .ready_i(ready_i),
        .error_o(error_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: packet handshakes and error pulses against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (!reset_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pkt: got len %0d data %h expected none", len_o, data_o);
            end else begin
                pkt_t p;
                p = exp_q.pop_front();
                check("pkt_data", data_o, p.data);
                check("pkt_len", DW'(len_o), DW'(p.len));
                hs_cyc.push_back(cyc);
            end
        end
        if (!reset_i && error_o) begin
            tests++;
            if (err_exp > 0) err_exp--;
            else begin
                fails++;
                $display("FAIL unexpected_error: got error_o=1 expected 0");
            end
        end
    end

    task automatic send(input logic [FW-1:0] f);
        int n;
        n = 0;
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = f;
        #1;
        while (!yumi_o && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!yumi_o) begin
            tests++;
            fails++;
            $display("FAIL yumi_timeout: got no yumi_o for flit %h expected accept", f);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    task automatic expect_pkt(input logic [DW-1:0] d, input logic [LW-1:0] l);
        pkt_t p;
        p.data = d;
        p.len  = l;
        exp_q.push_back(p);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [FW-1:0] h;
        logic [DW-1:0] d2;

        // Reset: yumi blocked even with a flit waiting, outputs cleared.
        valid_i = 1'b1;
        data_i  = 64'hDEAD_0000_0000_0001;
        repeat (3) @(negedge clk);
        #1;
        check("rst_yumi", DW'(yumi_o), DW'(0));
        check("rst_valid", DW'(valid_o), DW'(0));
        check("rst_data", data_o, '0);
        check("rst_len", DW'(len_o), DW'(0));
        check("rst_error", DW'(error_o), DW'(0));
        @(negedge clk);
        reset_i = 1'b0;
        valid_i = 1'b0;

        // len=2 packet, bubble in eDone, valid drops after handshake.
        h = 64'hC0DE_0000_0000_0002;
        expect_pkt({64'h0, 64'hB, 64'hA, h}, 8'd2);
        send(h);
        send(64'hA);
        send(64'hB);
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 64'hFFFF;
        #1;
        check("done_yumi", DW'(yumi_o), DW'(0));
        check("done_valid", DW'(valid_o), DW'(1));
        @(negedge clk);
        #1;
        check("post_hs_valid", DW'(valid_o), DW'(0));
        check("post_hs_yumi", DW'(yumi_o), DW'(1));
        valid_i = 1'b0;

        // len=0 packet held by ready_i=0 for 5 cycles.
        @(negedge clk);
        ready_i = 1'b0;
        h  = 64'h5555_0000_0000_0000;
        d2 = {64'h0, 64'h0, 64'h0, h};
        expect_pkt(d2, 8'd0);
        send(h);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            data_i  = 64'h9999;
            #1;
            check("hold_valid", DW'(valid_o), DW'(1));
            check("hold_yumi", DW'(yumi_o), DW'(0));
            check("hold_data", data_o, d2);
        end
        @(negedge clk);
        ready_i = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        #1;
        check("len0_release", DW'(valid_o), DW'(0));

        // Oversized len=5: drained with one error pulse, then a len=1 packet.
        err_exp++;
        send(64'h0000_0000_0000_0005);
        for (int i = 0; i < 5; i++) send(64'h100 + FW'(i));
        h = 64'h0101_0000_0000_0001;
        expect_pkt({64'h0, 64'h0, 64'hBEEF, h}, 8'd1);
        send(h);
        send(64'hBEEF);
        idle(3);

        // len=3 (max) with valid_i toggling each cycle.
        h = 64'h3333_0000_0000_0003;
        expect_pkt({64'hB3, 64'hB2, 64'hB1, h}, 8'd3);
        send(h);
        idle(1);
        send(64'hB1);
        idle(1);
        send(64'hB2);
        idle(1);
        send(64'hB3);
        idle(3);

        // Reset after header + 1 body of a len=3 packet.
        send(64'h7777_0000_0000_0003);
        send(64'h1111);
        @(negedge clk);
        reset_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 64'h2222;
        #1;
        check("midrst_yumi", DW'(yumi_o), DW'(0));
        @(negedge clk);
        reset_i = 1'b0;
        valid_i = 1'b0;
        #1;
        check("midrst_valid", DW'(valid_o), DW'(0));
        check("midrst_data", data_o, '0);
        h = 64'h8888_0000_0000_0001;
        expect_pkt({64'h0, 64'h0, 64'hCAFE, h}, 8'd1);
        send(h);
        send(64'hCAFE);
        idle(3);

        // Back-to-back len=1 packets: one every 3 cycles.
        hs_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            h = 64'hAB00_0000_0000_0001 | (FW'(i) << 16);
            expect_pkt({64'h0, 64'h0, 64'hF00 + FW'(i), h}, 8'd1);
            send(h);
            send(64'hF00 + FW'(i));
        end
        idle(4);
        check("b2b_count", DW'(hs_cyc.size()), DW'(4));
        for (int i = 1; i < hs_cyc.size(); i++)
            check("b2b_spacing", DW'(hs_cyc[i] - hs_cyc[i-1]), DW'(3));

        // Maximum-length discard (255) must drain without wrapping.
        err_exp++;
        send(64'h0000_0000_0000_00FF);
        for (int i = 0; i < 255; i++) send(64'h5000 + FW'(i));
        h = 64'h4444_0000_0000_0001;
        expect_pkt({64'h0, 64'h0, 64'hD00D, h}, 8'd1);
        send(h);
        send(64'hD00D);
        idle(5);

        check("pkts_pending", DW'(exp_q.size()), DW'(0));
        check("errors_missing", DW'(err_exp), DW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
